tlp_tx_arb: RTL and testbench
=============================

TLP_TX_ARB -- requirements
Module: tlp_tx_arb

Interface
REQ-001 Parameter NUM_SRC, default 4, number of packet sources; legal range 2..8.
REQ-002 Parameter ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-003 pcieClk_in  input  1  sole clock, 125MHz PCIe core clock; one clock, reset is synchronous and active-high.
REQ-004 reset_in  input  1  synchronous active-high reset.
REQ-005 srcData_in  input  NUM_SRC x 64  per-source TLP data word (uint64).
REQ-006 srcValid_in  input  NUM_SRC  per-source word valid.
REQ-007 srcReady_out  output  NUM_SRC  per-source word accepted when valid and ready are both high.
REQ-008 srcSOP_in  input  NUM_SRC  per-source start of packet.
REQ-009 srcEOP_in  input  NUM_SRC  per-source end of packet.
REQ-010 txData_out  output  64  merged TLP word to PCIe core.
REQ-011 txValid_out  output  1  tx word valid.
REQ-012 txReady_in  input  1  PCIe core accepts word.
REQ-013 txSOP_out  output  1  merged start of packet.
REQ-014 txEOP_out  output  1  merged end of packet.
REQ-015 grant_out  output  clog2(NUM_SRC)  index of the currently locked source; holds the last value when idle.
REQ-016 errDrop_out  output  1  one-cycle pulse when a non-SOP word is discarded in IDLE.

Function
REQ-017 The FSM SHALL have two states, IDLE and LOCKED.
REQ-018 In IDLE, a winner SHALL be chosen combinationally among sources with valid and SOP high.
- ARB_MODE=0: search starts at rrPtr and wraps modulo NUM_SRC.
- ARB_MODE=1: lowest index wins.
REQ-019 In IDLE, the winner's ready SHALL be asserted in the same cycle it is chosen, so back-to-back packets have no bubble.
REQ-020 In LOCKED, only srcReady_out[grant] SHALL be asserted; all other readies SHALL be 0.
REQ-021 srcReady_out SHALL also require the skid buffer not-full flag, which is registered.
REQ-022 An accepted SOP word without EOP SHALL move the FSM IDLE->LOCKED.
REQ-023 An accepted EOP word SHALL move the FSM LOCKED->IDLE.
REQ-024 A single-word packet (SOP and EOP together) SHALL leave the FSM in IDLE.
REQ-025 On every accepted EOP word, rrPtr SHALL become (grant+1) mod NUM_SRC; ARB_MODE=1 SHALL ignore rrPtr.
REQ-026 In IDLE, a valid word without SOP on any source SHALL be accepted and discarded, lowest index first, one per cycle, with errDrop_out pulsed.
REQ-027 A SOP word arriving while LOCKED SHALL be forwarded unchanged; the block SHALL NOT repair or re-frame it.
REQ-028 Accepted words SHALL pass through a 2-entry skid buffer, appearing on tx exactly 1 cycle after acceptance when txReady_in is high.
REQ-029 Output data and flags SHALL hold stable while txValid_out=1 and txReady_in=0.
REQ-030 With txReady_in held high and sources continuously valid, throughput SHALL be 1 word per cycle.

Reset
REQ-031 On reset_in the block SHALL enter IDLE with rrPtr=0, grant_out=0, skid buffer empty, txValid_out=0, srcReady_out=0 and errDrop_out=0.
REQ-032 A reset asserted mid-packet SHALL abandon the packet and flush the skid buffer; downstream reset is the integrator's responsibility.
REQ-033 Reset SHALL take priority over any simultaneous transfer.

Configuration
REQ-034 With macro TLP_TX_ARB_STATS_EN defined, an extra output pktCount_out (NUM_SRC x 16) SHALL exist.
- Each counter increments on every accepted EOP word from that source.
- Counters wrap 0xFFFF->0 and reset to 0.
REQ-035 Without TLP_TX_ARB_STATS_EN, pktCount_out and its counters SHALL be absent, with no other behavioural change.

Structure
REQ-036 The uint64 typedef, the ArbMode enum and the FSM state enum SHALL live in tlp_xcvr_pkg.
REQ-037 The skid buffer SHALL be a sub-module named tlp_skid, parametrised by width (64+2 here).

Verification
REQ-038 Single source: src0 sends a 3-word packet (0x11,0x22,0x33) with tx always ready -> tx shows the same 3 words 1 cycle later, SOP on 0x11, EOP on 0x33, grant_out=0.
REQ-039 RR fairness: NUM_SRC=4, all sources continuously offer 2-word packets -> tx grant order 0,1,2,3,0, no idle cycles between packets.
REQ-040 Priority mode: ARB_MODE=1, src1 and src3 both offer packets -> src1's packet completes first, then src3's.
REQ-041 Backpressure: txReady_in low for 5 cycles mid-packet -> no word lost or duplicated, tx output stable while stalled, srcReady_out low once the skid buffer is full.
REQ-042 Orphan word: src2 valid without SOP in IDLE with data 0xDEAD -> word consumed, errDrop_out pulses once, nothing appears on tx.
REQ-043 Reset mid-packet, with TLP_TX_ARB_STATS_EN: reset after word 2 of 4 -> txValid_out=0 next cycle, FSM IDLE, pktCount_out all 0; a following packet is forwarded normally.

Source files
------------

// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the PCIe TLP transmit path: data word, arbitration mode, arbiter FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tlp_xcvr_pkg;

    typedef logic [63:0] uint64;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int TLP_W = 64;

    // One word as it travels through the skid buffer: framing flags plus data.
    typedef struct packed {
        logic  sop;
        logic  eop;
        uint64 dat;
    } tlp_beat_t;

endpackage

// File: rtl/tlp_skid.sv
// Two-entry skid buffer between the source arbiter and the PCIe core.
// Latency: a word written on edge N is presented on out_* from edge N onwards (1 cycle).
// Backpressure: in_rdy is a registered not-full flag; out_* hold while out_vld && !out_rdy.
module tlp_skid #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         full_q;
    logic         push;
    logic         pop;

    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    assign in_rdy  = !full_q;
    assign out_vld = (count != 2'd0);
    assign out_dat = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; also feeds the registered full flag.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (!push && pop) begin
            count_nxt = count - 2'd1;
        end
    end

    // Storage has no reset: out_vld masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointer, occupancy and full-flag registers; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            full_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count  <= count_nxt;
            full_q <= (count_nxt == 2'd2);
        end
    end

endmodule

// File: rtl/tlp_tx_arb.sv
// Merges NUM_SRC TLP word streams into one PCIe core stream, locking onto a source for a whole packet.
// Latency: accepted word appears on tx 1 cycle after acceptance; no bubble between packets.
// Backpressure: srcReady_out follows the skid buffer's registered not-full flag. Optional macro TLP_TX_ARB_STATS_EN adds pktCount_out.
module tlp_tx_arb
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                       pcieClk_in,
    input  logic                       reset_in,
    input  logic [NUM_SRC*64-1:0]      srcData_in,
    input  logic [NUM_SRC-1:0]         srcValid_in,
    output logic [NUM_SRC-1:0]         srcReady_out,
    input  logic [NUM_SRC-1:0]         srcSOP_in,
    input  logic [NUM_SRC-1:0]         srcEOP_in,
    output logic [63:0]                txData_out,
    output logic                       txValid_out,
    input  logic                       txReady_in,
    output logic                       txSOP_out,
    output logic                       txEOP_out,
    output logic [$clog2(NUM_SRC)-1:0] grant_out,
    output logic                       errDrop_out
`ifdef TLP_TX_ARB_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]      pktCount_out
`endif
);

    localparam int        GW   = $clog2(NUM_SRC);
    localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] rr_ptr_q;
    logic          err_drop_q;
    logic          not_full;
    logic [GW-1:0] sel;
    logic [GW-1:0] idx;
    logic          sel_vld;
    logic          fwd;
    logic          acc;
    logic          fwd_acc;
    logic          drop_acc;
    logic          eop_acc;
    uint64         src_dat [NUM_SRC];
    tlp_beat_t     beat_in;
    tlp_beat_t     beat_out;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_dat[g] = srcData_in[g*TLP_W +: TLP_W];
    end

    // Pick the source offered ready this cycle: the locked source, else a SOP winner, else an orphan to drop.
    always_comb begin
        sel     = grant_q;
        idx     = '0;
        sel_vld = 1'b0;
        fwd     = 1'b0;
        if (state_q == ST_LOCKED) begin
            sel_vld = 1'b1;
            fwd     = 1'b1;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (MODE == ARB_FIXED) begin
                    idx = GW'(k);
                end else begin
                    idx = GW'((int'(rr_ptr_q) + k) % NUM_SRC);
                end
                if (!sel_vld && srcValid_in[idx] && srcSOP_in[idx]) begin
                    sel     = idx;
                    sel_vld = 1'b1;
                    fwd     = 1'b1;
                end
            end
            // Orphans only drain when no packet is waiting to start.
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!sel_vld && srcValid_in[k] && !srcSOP_in[k]) begin
                    sel     = GW'(k);
                    sel_vld = 1'b1;
                end
            end
        end
    end

    // Ready goes only to the selected source; reset masks it so nothing is lost during reset.
    always_comb begin
        srcReady_out = '0;
        if (sel_vld && not_full && !reset_in) begin
            srcReady_out[sel] = 1'b1;
        end
    end

    assign acc      = sel_vld && srcValid_in[sel] && not_full && !reset_in;
    assign fwd_acc  = acc && fwd;
    assign drop_acc = acc && !fwd;
    // Statistics and rr pointer follow forwarded words only; a dropped orphan never owned the link.
    assign eop_acc  = fwd_acc && srcEOP_in[sel];

    // Word handed to the skid buffer, framing flags passed through untouched.
    always_comb begin
        beat_in.sop = srcSOP_in[sel];
        beat_in.eop = srcEOP_in[sel];
        beat_in.dat = src_dat[sel];
    end

    // Lock on an accepted SOP without EOP; release on any accepted EOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fwd_acc && !srcEOP_in[sel]) state_d = ST_LOCKED;
            ST_LOCKED: if (fwd_acc && srcEOP_in[sel])  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM, grant, round-robin pointer and drop-pulse registers.
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_drop_q <= drop_acc;
            if (fwd_acc && state_q == ST_IDLE) begin
                grant_q <= sel;
            end
            if (eop_acc) begin
                rr_ptr_q <= (sel == GW'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    tlp_skid #(
        .W($bits(tlp_beat_t))
    ) u_skid (
        .clk     (pcieClk_in),
        .rst     (reset_in),
        .in_vld  (fwd_acc),
        .in_rdy  (not_full),
        .in_dat  (beat_in),
        .out_vld (txValid_out),
        .out_rdy (txReady_in),
        .out_dat (beat_out)
    );

    assign txData_out  = beat_out.dat;
    assign txSOP_out   = beat_out.sop;
    assign txEOP_out   = beat_out.eop;
    assign grant_out   = grant_q;
    assign errDrop_out = err_drop_q;

`ifdef TLP_TX_ARB_STATS_EN
    logic [15:0] pkt_cnt_q [NUM_SRC];

    // Per-source packet counters, wrapping naturally at 16 bits.
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                pkt_cnt_q[i] <= 16'd0;
            end
        end else if (eop_acc) begin
            pkt_cnt_q[sel] <= pkt_cnt_q[sel] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        assign pktCount_out[g*16 +: 16] = pkt_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Directed bench for tlp_tx_arb: round-robin instance (a) and fixed-priority instance (b).
// Sources are fed from per-source word queues; tx beats are logged for ordering checks.
// Optional macro TLP_TX_ARB_STATS_EN enables packet-counter checks.
module tb_tlp_tx_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic flush_req = 1'b0;

    logic [255:0] a_dat = '0;
    logic [3:0]   a_vld = '0, a_sop = '0, a_eop = '0, a_rdy;
    logic [63:0]  a_tx_dat;
    logic         a_tx_vld, a_tx_sop, a_tx_eop, a_err;
    logic         a_tx_rdy = 1'b1;
    logic [1:0]   a_gnt;

    logic [255:0] b_dat = '0;
    logic [3:0]   b_vld = '0, b_sop = '0, b_eop = '0, b_rdy;
    logic [63:0]  b_tx_dat;
    logic         b_tx_vld, b_tx_sop, b_tx_eop, b_err;
    logic         b_tx_rdy = 1'b1;
    logic [1:0]   b_gnt;
`ifdef TLP_TX_ARB_STATS_EN
    logic [63:0]  a_cnt, b_cnt;
`endif

    tlp_tx_arb #(.NUM_SRC(4), .ARB_MODE(0)) dut_a (
        .pcieClk_in(clk), .reset_in(rst),
        .srcData_in(a_dat), .srcValid_in(a_vld), .srcReady_out(a_rdy),
        .srcSOP_in(a_sop), .srcEOP_in(a_eop),
        .txData_out(a_tx_dat), .txValid_out(a_tx_vld), .txReady_in(a_tx_rdy),
        .txSOP_out(a_tx_sop), .txEOP_out(a_tx_eop),
        .grant_out(a_gnt), .errDrop_out(a_err)
`ifdef TLP_TX_ARB_STATS_EN
        , .pktCount_out(a_cnt)
`endif
    );

    tlp_tx_arb #(.NUM_SRC(4), .ARB_MODE(1)) dut_b (
        .pcieClk_in(clk), .reset_in(rst),
        .srcData_in(b_dat), .srcValid_in(b_vld), .srcReady_out(b_rdy),
        .srcSOP_in(b_sop), .srcEOP_in(b_eop),
        .txData_out(b_tx_dat), .txValid_out(b_tx_vld), .txReady_in(b_tx_rdy),
        .txSOP_out(b_tx_sop), .txEOP_out(b_tx_eop),
        .grant_out(b_gnt), .errDrop_out(b_err)
`ifdef TLP_TX_ARB_STATS_EN
        , .pktCount_out(b_cnt)
`endif
    );

    // Source queues: slots 0-3 feed dut_a, 4-7 feed dut_b. Entry = {sop, eop, data}.
    logic [65:0] smem [8][32];
    int shead [8] = '{default: 0};
    int stail [8] = '{default: 0};

    always @(posedge clk) begin
        logic [7:0]  acc;
        logic [65:0] w;
        logic        has;
        acc = {b_vld & b_rdy, a_vld & a_rdy};
        #1;
        for (int i = 0; i < 8; i++) begin
            if (flush_req) shead[i] = stail[i];
            else if (acc[i]) shead[i] = shead[i] + 1;
            has = (shead[i] != stail[i]);
            w   = has ? smem[i][shead[i]] : 66'd0;
            if (i < 4) begin
                a_vld[i] = has; a_sop[i] = w[65]; a_eop[i] = w[64];
                a_dat[i*64 +: 64] = w[63:0];
            end else begin
                b_vld[i-4] = has; b_sop[i-4] = w[65]; b_eop[i-4] = w[64];
                b_dat[(i-4)*64 +: 64] = w[63:0];
            end
        end
    end

    // tx beat logs; beats taken while reset is high are flushed by the DUT, so not logged.
    logic [65:0] alog [64];
    logic [65:0] blog [64];
    int acyc [64];
    int an = 0, bn = 0, cyc = 0, aerr = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && a_tx_vld && a_tx_rdy) begin
            alog[an] = {a_tx_sop, a_tx_eop, a_tx_dat}; acyc[an] = cyc; an = an + 1;
        end
        if (!rst && b_tx_vld && b_tx_rdy) begin
            blog[bn] = {b_tx_sop, b_tx_eop, b_tx_dat}; bn = bn + 1;
        end
    end

    always @(negedge clk) if (a_err === 1'b1) aerr = aerr + 1;

    int n_pass = 0, n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] bt(input logic s, input logic e, input logic [63:0] d);
        return {s, e, d};
    endfunction

    task automatic push(input int s, input logic sop, input logic eop, input logic [63:0] d);
        smem[s][stail[s]] = {sop, eop, d};
        stail[s] = stail[s] + 1;
    endtask

    task automatic wait_a(input int target, input int budget, input string tag);
        int k = 0;
        while (an < target && k < budget) begin @(negedge clk); k++; end
        check(tag, 66'(an), 66'(target));
    endtask

    task automatic wait_b(input int target, input int budget, input string tag);
        int k = 0;
        while (bn < target && k < budget) begin @(negedge clk); k++; end
        check(tag, 66'(bn), 66'(target));
    endtask

    function automatic logic [65:0] atx();
        return {a_tx_sop, a_tx_eop, a_tx_dat};
    endfunction

    initial begin
        int base;
        int ebase;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txvld", 66'(a_tx_vld), 66'(0));
        check("rst_rdy",   66'(a_rdy),    66'(0));
        check("rst_grant", 66'(a_gnt),    66'(0));
        check("rst_err",   66'(a_err),    66'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_txvld", 66'(a_tx_vld), 66'(0));

        // Single source, 3-word packet, cycle-exact
        push(0, 1'b1, 1'b0, 64'h11); push(0, 1'b0, 1'b0, 64'h22); push(0, 1'b0, 1'b1, 64'h33);
        @(negedge clk);
        check("t1_rdy_same_cycle", 66'(a_rdy), 66'(4'b0001));
        check("t1_txvld_before", 66'(a_tx_vld), 66'(0));
        @(negedge clk); check("t1_w0", atx(), bt(1'b1, 1'b0, 64'h11));
        check("t1_grant", 66'(a_gnt), 66'(0));
        @(negedge clk); check("t1_w1", atx(), bt(1'b0, 1'b0, 64'h22));
        @(negedge clk); check("t1_w2", atx(), bt(1'b0, 1'b1, 64'h33));
        @(negedge clk); check("t1_empty", 66'(a_tx_vld), 66'(0));

        // Round-robin fairness from rr_ptr=0, all sources busy
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        base = an;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++) begin
                push(s, 1'b1, 1'b0, 64'(s * 256 + p * 16));
                push(s, 1'b0, 1'b1, 64'(s * 256 + p * 16 + 1));
            end
        wait_a(base + 16, 80, "rr_timeout");
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++) begin
                check("rr_sop", alog[base + p*8 + s*2],     bt(1'b1, 1'b0, 64'(s * 256 + p * 16)));
                check("rr_eop", alog[base + p*8 + s*2 + 1], bt(1'b0, 1'b1, 64'(s * 256 + p * 16 + 1)));
            end
        check("rr_no_bubble", 66'(acyc[base + 15] - acyc[base]), 66'(15));
        check("rr_grant_hold", 66'(a_gnt), 66'(3));
`ifdef TLP_TX_ARB_STATS_EN
        for (int s = 0; s < 4; s++) check("rr_cnt", 66'(a_cnt[s*16 +: 16]), 66'(2));
`endif

        // Fixed priority: src2 first moves any rr pointer to 3, yet src1 must beat src3
        push(6, 1'b1, 1'b1, 64'h200);
        wait_b(1, 20, "fp_pre_timeout");
        push(5, 1'b1, 1'b0, 64'h110); push(5, 1'b0, 1'b1, 64'h111);
        push(7, 1'b1, 1'b0, 64'h310); push(7, 1'b0, 1'b1, 64'h311);
        wait_b(5, 30, "fp_timeout");
        check("fp_0", blog[0], bt(1'b1, 1'b1, 64'h200));
        check("fp_1", blog[1], bt(1'b1, 1'b0, 64'h110));
        check("fp_2", blog[2], bt(1'b0, 1'b1, 64'h111));
        check("fp_3", blog[3], bt(1'b1, 1'b0, 64'h310));
        check("fp_4", blog[4], bt(1'b0, 1'b1, 64'h311));
        check("fp_grant", 66'(b_gnt), 66'(3));

        // Backpressure: stall 5 cycles with the first word on tx
        base = an;
        push(0, 1'b1, 1'b0, 64'h40); push(0, 1'b0, 1'b0, 64'h41);
        push(0, 1'b0, 1'b0, 64'h42); push(0, 1'b0, 1'b1, 64'h43);
        @(negedge clk); @(negedge clk);
        check("bp_first", atx(), bt(1'b1, 1'b0, 64'h40));
        a_tx_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold", {a_tx_vld, atx()} , {1'b1, bt(1'b1, 1'b0, 64'h40)});
            check("bp_rdy_low", 66'(a_rdy), 66'(0));
        end
        a_tx_rdy = 1'b1;
        wait_a(base + 4, 30, "bp_timeout");
        repeat (3) @(negedge clk);
        check("bp_count", 66'(an), 66'(base + 4));
        check("bp_0", alog[base],     bt(1'b1, 1'b0, 64'h40));
        check("bp_1", alog[base + 1], bt(1'b0, 1'b0, 64'h41));
        check("bp_2", alog[base + 2], bt(1'b0, 1'b0, 64'h42));
        check("bp_3", alog[base + 3], bt(1'b0, 1'b1, 64'h43));

        // Orphan word in IDLE
        base = an; ebase = aerr;
        push(2, 1'b0, 1'b0, 64'hDEAD);
        repeat (6) @(negedge clk);
        check("orph_pulse", 66'(aerr - ebase), 66'(1));
        check("orph_no_tx", 66'(an), 66'(base));
        check("orph_consumed", 66'(stail[2] - shead[2]), 66'(0));

        // Reset after word 2 of 4, then a normal packet
        base = an;
        push(1, 1'b1, 1'b0, 64'h50); push(1, 1'b0, 1'b0, 64'h51);
        push(1, 1'b0, 1'b0, 64'h52); push(1, 1'b0, 1'b1, 64'h53);
        repeat (3) @(negedge clk);
        check("rm_w1_on_tx", atx(), bt(1'b0, 1'b0, 64'h51));
        rst = 1'b1; flush_req = 1'b1;
        @(negedge clk);
        check("rm_txvld", 66'(a_tx_vld), 66'(0));
        check("rm_rdy",   66'(a_rdy),    66'(0));
        check("rm_grant", 66'(a_gnt),    66'(0));
`ifdef TLP_TX_ARB_STATS_EN
        check("rm_cnt", 66'(a_cnt), 66'(0));
`endif
        rst = 1'b0; flush_req = 1'b0;
        push(3, 1'b1, 1'b0, 64'h60); push(3, 1'b0, 1'b1, 64'h61);
        wait_a(base + 3, 30, "rm_timeout");
        check("rm_0", alog[base],     bt(1'b1, 1'b0, 64'h50));
        check("rm_1", alog[base + 1], bt(1'b1, 1'b0, 64'h60));
        check("rm_2", alog[base + 2], bt(1'b0, 1'b1, 64'h61));
`ifdef TLP_TX_ARB_STATS_EN
        check("rm_cnt3", 66'(a_cnt[63:48]), 66'(1));
`endif
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
